// File: rtl/store_queue_fwd.sv
// Store queue with a speculative FIFO feeding a commit FIFO that drains to memory.
// Loads look up both FIFOs combinationally and either forward the youngest
// matching store's data or stall when that store's bytes do not cover the load.
module store_queue_fwd #(
   parameter int unsigned SPEC_DEPTH   = 4,
   parameter int unsigned COMMIT_DEPTH = 4,
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned ADDR_W       = 56
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic [ADDR_W-1:0]   paddr_i,
   input  logic [DATA_W-1:0]   data_i,
   input  logic [DATA_W/8-1:0] be_i,
   input  logic [1:0]          size_i,
   input  logic                commit_i,
   output logic                commit_ready_o,
   output logic                no_st_pending_o,
   input  logic                ld_valid_i,
   input  logic [ADDR_W-1:0]   ld_paddr_i,
   input  logic [DATA_W/8-1:0] ld_be_i,
   output logic                fwd_hit_o,
   output logic [DATA_W-1:0]   fwd_data_o,
   output logic                ld_stall_o,
   output logic                mem_req_o,
   input  logic                mem_gnt_i,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_data_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [1:0]          mem_size_o
);
   localparam int unsigned BE_W = DATA_W / 8;
   localparam int unsigned SPW  = $clog2(SPEC_DEPTH);
   localparam int unsigned CPW  = $clog2(COMMIT_DEPTH);
   localparam int unsigned OFF  = $clog2(BE_W);
   localparam logic [SPW:0] SPEC_FULL   = (SPW+1)'(SPEC_DEPTH);
   localparam logic [CPW:0] COMMIT_FULL = (CPW+1)'(COMMIT_DEPTH);

   logic [SPW-1:0]    spec_rd_q, spec_rd_d, spec_wr_q, spec_wr_d;
   logic [SPW:0]      spec_cnt_q, spec_cnt_d;
   logic [CPW-1:0]    cq_rd_q, cq_rd_d, cq_wr_q, cq_wr_d;
   logic [CPW:0]      commit_cnt_q, commit_cnt_d;

   logic [ADDR_W-1:0] sq_addr_q [SPEC_DEPTH];
   logic [DATA_W-1:0] sq_data_q [SPEC_DEPTH];
   logic [BE_W-1:0]   sq_be_q   [SPEC_DEPTH];
   logic [1:0]        sq_size_q [SPEC_DEPTH];
   logic              sq_vld_q  [SPEC_DEPTH];
   logic [ADDR_W-1:0] cq_addr_q [COMMIT_DEPTH];
   logic [DATA_W-1:0] cq_data_q [COMMIT_DEPTH];
   logic [BE_W-1:0]   cq_be_q   [COMMIT_DEPTH];
   logic [1:0]        cq_size_q [COMMIT_DEPTH];
   logic              cq_vld_q  [COMMIT_DEPTH];

   logic push, commit_fire, gnt_fire;

   // Handshakes: a commit frees a speculative slot in the same cycle
   assign commit_ready_o  = commit_cnt_q < COMMIT_FULL;
   assign commit_fire     = commit_i & commit_ready_o & (spec_cnt_q != '0);
   assign ready_o         = (spec_cnt_q < SPEC_FULL) | commit_fire;
   assign push            = valid_i & ready_o & ~flush_i;
   assign mem_req_o       = cq_vld_q[cq_rd_q];
   assign gnt_fire        = mem_gnt_i & mem_req_o;
   assign no_st_pending_o = (commit_cnt_q == '0);
   assign mem_addr_o      = cq_addr_q[cq_rd_q];
   assign mem_data_o      = cq_data_q[cq_rd_q];
   assign mem_be_o        = cq_be_q[cq_rd_q];
   assign mem_size_o      = cq_size_q[cq_rd_q];

   // Pointer and occupancy next-state; flush resets the speculative FIFO after any commit
   always_comb begin
      spec_rd_d    = spec_rd_q;
      spec_wr_d    = spec_wr_q;
      cq_rd_d      = cq_rd_q;
      cq_wr_d      = cq_wr_q;
      if (commit_fire) spec_rd_d = spec_rd_q + SPW'(1);
      if (push)        spec_wr_d = spec_wr_q + SPW'(1);
      if (commit_fire) cq_wr_d   = cq_wr_q + CPW'(1);
      if (gnt_fire)    cq_rd_d   = cq_rd_q + CPW'(1);
      spec_cnt_d   = spec_cnt_q + (SPW+1)'(push) - (SPW+1)'(commit_fire);
      commit_cnt_d = commit_cnt_q + (CPW+1)'(commit_fire) - (CPW+1)'(gnt_fire);
      if (flush_i) begin
         spec_wr_d  = spec_rd_d;
         spec_cnt_d = '0;
      end
   end

   // Queue state and entry storage
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         spec_rd_q    <= '0;
         spec_wr_q    <= '0;
         spec_cnt_q   <= '0;
         cq_rd_q      <= '0;
         cq_wr_q      <= '0;
         commit_cnt_q <= '0;
         for (int i = 0; i < SPEC_DEPTH; i++) begin
            sq_addr_q[i] <= '0;
            sq_data_q[i] <= '0;
            sq_be_q[i]   <= '0;
            sq_size_q[i] <= '0;
            sq_vld_q[i]  <= 1'b0;
         end
         for (int i = 0; i < COMMIT_DEPTH; i++) begin
            cq_addr_q[i] <= '0;
            cq_data_q[i] <= '0;
            cq_be_q[i]   <= '0;
            cq_size_q[i] <= '0;
            cq_vld_q[i]  <= 1'b0;
         end
      end else begin
         spec_rd_q    <= spec_rd_d;
         spec_wr_q    <= spec_wr_d;
         spec_cnt_q   <= spec_cnt_d;
         cq_rd_q      <= cq_rd_d;
         cq_wr_q      <= cq_wr_d;
         commit_cnt_q <= commit_cnt_d;
         // Clear before set so a push into the slot just committed keeps its valid bit
         if (commit_fire) sq_vld_q[spec_rd_q] <= 1'b0;
         if (flush_i) begin
            for (int i = 0; i < SPEC_DEPTH; i++) sq_vld_q[i] <= 1'b0;
         end
         if (push) begin
            sq_addr_q[spec_wr_q] <= paddr_i;
            sq_data_q[spec_wr_q] <= data_i;
            sq_be_q[spec_wr_q]   <= be_i;
            sq_size_q[spec_wr_q] <= size_i;
            sq_vld_q[spec_wr_q]  <= 1'b1;
         end
         if (gnt_fire) cq_vld_q[cq_rd_q] <= 1'b0;
         if (commit_fire) begin
            cq_addr_q[cq_wr_q] <= sq_addr_q[spec_rd_q];
            cq_data_q[cq_wr_q] <= sq_data_q[spec_rd_q];
            cq_be_q[cq_wr_q]   <= sq_be_q[spec_rd_q];
            cq_size_q[cq_wr_q] <= sq_size_q[spec_rd_q];
            cq_vld_q[cq_wr_q]  <= 1'b1;
         end
      end
   end

   // Load lookup: walk oldest to youngest so the last match is the youngest;
   // speculative entries are younger than every committed one, so they override
   always_comb begin
      logic [CPW-1:0]    cidx;
      logic [SPW-1:0]    sidx;
      logic              match, push_match;
      logic [DATA_W-1:0] sel_data;
      logic [BE_W-1:0]   sel_be;
      cidx       = '0;
      sidx       = '0;
      match      = 1'b0;
      sel_data   = '0;
      sel_be     = '0;
      fwd_hit_o  = 1'b0;
      fwd_data_o = '0;
      ld_stall_o = 1'b0;
      for (int k = 0; k < COMMIT_DEPTH; k++) begin
         cidx = cq_rd_q + CPW'(k);
         if (cq_vld_q[cidx] && cq_addr_q[cidx][ADDR_W-1:OFF] == ld_paddr_i[ADDR_W-1:OFF]) begin
            match    = 1'b1;
            sel_data = cq_data_q[cidx];
            sel_be   = cq_be_q[cidx];
         end
      end
      for (int k = 0; k < SPEC_DEPTH; k++) begin
         sidx = spec_rd_q + SPW'(k);
         if (sq_vld_q[sidx] && sq_addr_q[sidx][ADDR_W-1:OFF] == ld_paddr_i[ADDR_W-1:OFF]) begin
            match    = 1'b1;
            sel_data = sq_data_q[sidx];
            sel_be   = sq_be_q[sidx];
         end
      end
      push_match = push && (paddr_i[ADDR_W-1:OFF] == ld_paddr_i[ADDR_W-1:OFF]);
      if (ld_valid_i) begin
         if (push_match || (match && ((ld_be_i & ~sel_be) != '0))) begin
            ld_stall_o = 1'b1;
         end else if (match) begin
            fwd_hit_o  = 1'b1;
            fwd_data_o = sel_data;
         end
      end
   end
endmodule

// File: tb/tb_store_queue_fwd.sv
// Directed bench for store_queue_fwd with default parameters.
module tb_store_queue_fwd;
   logic        clk_i = 1'b0;
   logic        rst_i, flush_i, valid_i, ready_o;
   logic [55:0] paddr_i, ld_paddr_i, mem_addr_o;
   logic [63:0] data_i, fwd_data_o, mem_data_o;
   logic [7:0]  be_i, ld_be_i, mem_be_o;
   logic [1:0]  size_i, mem_size_o;
   logic        commit_i, commit_ready_o, no_st_pending_o, ld_valid_i;
   logic        fwd_hit_o, ld_stall_o, mem_req_o, mem_gnt_i;
   int          nvec = 0;
   int          nerr = 0;

   store_queue_fwd dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
      .paddr_i(paddr_i), .data_i(data_i), .be_i(be_i), .size_i(size_i),
      .commit_i(commit_i), .commit_ready_o(commit_ready_o), .no_st_pending_o(no_st_pending_o),
      .ld_valid_i(ld_valid_i), .ld_paddr_i(ld_paddr_i), .ld_be_i(ld_be_i),
      .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o), .ld_stall_o(ld_stall_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_be_o(mem_be_o), .mem_size_o(mem_size_o));

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1; flush_i = 0; valid_i = 0; commit_i = 0; ld_valid_i = 0; mem_gnt_i = 0;
      paddr_i = '0; data_i = '0; be_i = '0; size_i = '0; ld_paddr_i = '0; ld_be_i = '0;
      tick();
      rst_i = 1'b0;
      tick();
   endtask

   task automatic push(input logic [55:0] a, input logic [63:0] d, input logic [7:0] be);
      valid_i = 1; paddr_i = a; data_i = d; be_i = be; size_i = 2'd3;
      tick();
      valid_i = 0;
   endtask

   task automatic lookup(input logic [55:0] a, input logic [7:0] be);
      ld_valid_i = 1; ld_paddr_i = a; ld_be_i = be;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      rst_i = 1; #1;
      nvec++; if ({ready_o, commit_ready_o, no_st_pending_o, mem_req_o, fwd_hit_o, ld_stall_o} !== 6'b111000) begin
         nerr++; $display("FAIL reset_outs got %b want 111000", {ready_o, commit_ready_o, no_st_pending_o, mem_req_o, fwd_hit_o, ld_stall_o}); end
      rst_i = 0; tick();
   endtask

   task automatic test_commit_drain();
      do_reset();
      push(56'h100, 64'h1111111111111111, 8'hFF);
      commit_i = 1; tick(); commit_i = 0;
      tick(); #1;
      nvec++; if ({mem_req_o, no_st_pending_o} !== 2'b10 || mem_addr_o !== 56'h100) begin
         nerr++; $display("FAIL drain_req got req=%b nsp=%b addr=%h want 1 0 100", mem_req_o, no_st_pending_o, mem_addr_o); end
      nvec++; if (mem_data_o !== 64'h1111111111111111 || mem_be_o !== 8'hFF) begin
         nerr++; $display("FAIL drain_data got %h/%h want 1111111111111111/ff", mem_data_o, mem_be_o); end
      lookup(56'h100, 8'hFF);
      nvec++; if (fwd_hit_o !== 1'b1 || fwd_data_o !== 64'h1111111111111111) begin
         nerr++; $display("FAIL fwd_commitq got hit=%b data=%h want 1 1111111111111111", fwd_hit_o, fwd_data_o); end
      ld_valid_i = 0;
      mem_gnt_i = 1; tick(); mem_gnt_i = 0; #1;
      nvec++; if ({mem_req_o, no_st_pending_o} !== 2'b01) begin
         nerr++; $display("FAIL drain_done got req=%b nsp=%b want 0 1", mem_req_o, no_st_pending_o); end
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int i = 0; i < 4; i++) push(56'h300 + 56'(8*i), 64'(i+1), 8'hFF);
      #1;
      nvec++; if (ready_o !== 1'b0 || dut.spec_cnt_q !== 3'd4 || dut.spec_wr_q !== 2'd0) begin
         nerr++; $display("FAIL full got ready=%b cnt=%0d wr=%0d want 0 4 0", ready_o, dut.spec_cnt_q, dut.spec_wr_q); end
      push(56'h900, 64'h99, 8'hFF);
      lookup(56'h900, 8'hFF);
      nvec++; if (fwd_hit_o !== 1'b0 || dut.spec_cnt_q !== 3'd4) begin
         nerr++; $display("FAIL ignored_push got hit=%b cnt=%0d want 0 4", fwd_hit_o, dut.spec_cnt_q); end
      ld_valid_i = 0;
      commit_i = 1; valid_i = 1; paddr_i = 56'h340; data_i = 64'h5; be_i = 8'hFF; #1;
      nvec++; if (ready_o !== 1'b1) begin
         nerr++; $display("FAIL ready_with_commit got %b want 1", ready_o); end
      tick(); commit_i = 0; valid_i = 0; #1;
      nvec++; if (dut.spec_cnt_q !== 3'd4 || dut.commit_cnt_q !== 3'd1 || dut.spec_wr_q !== 2'd1 || dut.spec_rd_q !== 2'd1) begin
         nerr++; $display("FAIL push_commit got cnt=%0d ccnt=%0d wr=%0d rd=%0d want 4 1 1 1", dut.spec_cnt_q, dut.commit_cnt_q, dut.spec_wr_q, dut.spec_rd_q); end
      lookup(56'h340, 8'hFF);
      nvec++; if (fwd_hit_o !== 1'b1 || fwd_data_o !== 64'h5) begin
         nerr++; $display("FAIL wrapped_entry got hit=%b data=%h want 1 5", fwd_hit_o, fwd_data_o); end
      ld_valid_i = 0;
   endtask

   task automatic test_forward();
      do_reset();
      push(56'h200, 64'h1, 8'hFF);
      push(56'h200, 64'h2, 8'hFF);
      lookup(56'h204, 8'hF0);
      nvec++; if (fwd_hit_o !== 1'b1 || ld_stall_o !== 1'b0 || fwd_data_o !== 64'h2) begin
         nerr++; $display("FAIL fwd_youngest got hit=%b stall=%b data=%h want 1 0 2", fwd_hit_o, ld_stall_o, fwd_data_o); end
      ld_valid_i = 0; #1;
      nvec++; if (fwd_hit_o !== 1'b0 || fwd_data_o !== 64'h0) begin
         nerr++; $display("FAIL ld_idle got hit=%b data=%h want 0 0", fwd_hit_o, fwd_data_o); end
      do_reset();
      push(56'h200, 64'h3, 8'h0F);
      lookup(56'h200, 8'hFF);
      nvec++; if (fwd_hit_o !== 1'b0 || ld_stall_o !== 1'b1 || fwd_data_o !== 64'h0) begin
         nerr++; $display("FAIL partial_stall got hit=%b stall=%b data=%h want 0 1 0", fwd_hit_o, ld_stall_o, fwd_data_o); end
      lookup(56'h200, 8'h0F);
      nvec++; if (fwd_hit_o !== 1'b1 || fwd_data_o !== 64'h3) begin
         nerr++; $display("FAIL partial_cover got hit=%b data=%h want 1 3", fwd_hit_o, fwd_data_o); end
      lookup(56'h208, 8'hFF);
      nvec++; if (fwd_hit_o !== 1'b0 || ld_stall_o !== 1'b0) begin
         nerr++; $display("FAIL other_word got hit=%b stall=%b want 0 0", fwd_hit_o, ld_stall_o); end
      ld_valid_i = 0;
      do_reset();
      push(56'h400, 64'h5, 8'hFF);
      commit_i = 1; tick(); commit_i = 0;
      push(56'h400, 64'h6, 8'hF0);
      lookup(56'h400, 8'h0F);
      nvec++; if (fwd_hit_o !== 1'b0 || ld_stall_o !== 1'b1) begin
         nerr++; $display("FAIL spec_priority got hit=%b stall=%b want 0 1", fwd_hit_o, ld_stall_o); end
      lookup(56'h500, 8'hFF);
      valid_i = 1; paddr_i = 56'h500; data_i = 64'h7; be_i = 8'hFF; #1;
      nvec++; if (ld_stall_o !== 1'b1 || fwd_hit_o !== 1'b0) begin
         nerr++; $display("FAIL push_match got stall=%b hit=%b want 1 0", ld_stall_o, fwd_hit_o); end
      valid_i = 0; ld_valid_i = 0;
   endtask

   task automatic test_flush();
      do_reset();
      push(56'h600, 64'h7, 8'hFF);
      push(56'h608, 64'h8, 8'hFF);
      push(56'h610, 64'h9, 8'hFF);
      commit_i = 1; flush_i = 1; tick(); commit_i = 0; flush_i = 0; #1;
      nvec++; if (dut.commit_cnt_q !== 3'd1 || dut.spec_cnt_q !== 3'd0 || dut.spec_wr_q !== 2'd1) begin
         nerr++; $display("FAIL flush_cnt got ccnt=%0d cnt=%0d wr=%0d want 1 0 1", dut.commit_cnt_q, dut.spec_cnt_q, dut.spec_wr_q); end
      lookup(56'h608, 8'hFF);
      nvec++; if (fwd_hit_o !== 1'b0 || ld_stall_o !== 1'b0) begin
         nerr++; $display("FAIL flushed_608 got hit=%b stall=%b want 0 0", fwd_hit_o, ld_stall_o); end
      lookup(56'h610, 8'hFF);
      nvec++; if (fwd_hit_o !== 1'b0) begin
         nerr++; $display("FAIL flushed_610 got hit=%b want 0", fwd_hit_o); end
      lookup(56'h600, 8'hFF);
      nvec++; if (fwd_hit_o !== 1'b1 || fwd_data_o !== 64'h7) begin
         nerr++; $display("FAIL committed_600 got hit=%b data=%h want 1 7", fwd_hit_o, fwd_data_o); end
      ld_valid_i = 0;
      flush_i = 1; push(56'h700, 64'hA, 8'hFF); flush_i = 0;
      lookup(56'h700, 8'hFF);
      nvec++; if (fwd_hit_o !== 1'b0 || dut.spec_cnt_q !== 3'd0) begin
         nerr++; $display("FAIL flush_drop got hit=%b cnt=%0d want 0 0", fwd_hit_o, dut.spec_cnt_q); end
      ld_valid_i = 0;
   endtask

   task automatic test_commit_full();
      do_reset();
      for (int i = 0; i < 4; i++) push(56'h800 + 56'(8*i), 64'hA + 64'(i), 8'hFF);
      commit_i = 1;
      for (int i = 0; i < 4; i++) tick();
      commit_i = 0; #1;
      nvec++; if (commit_ready_o !== 1'b0 || dut.commit_cnt_q !== 3'd4) begin
         nerr++; $display("FAIL cq_full got rdy=%b ccnt=%0d want 0 4", commit_ready_o, dut.commit_cnt_q); end
      push(56'h820, 64'hE, 8'hFF);
      commit_i = 1; tick(); commit_i = 0; #1;
      nvec++; if (dut.spec_cnt_q !== 3'd1 || dut.commit_cnt_q !== 3'd4 || mem_addr_o !== 56'h800) begin
         nerr++; $display("FAIL commit_ignored got cnt=%0d ccnt=%0d addr=%h want 1 4 800", dut.spec_cnt_q, dut.commit_cnt_q, mem_addr_o); end
      mem_gnt_i = 1; tick(); mem_gnt_i = 0; #1;
      nvec++; if (dut.commit_cnt_q !== 3'd3 || mem_addr_o !== 56'h808 || commit_ready_o !== 1'b1) begin
         nerr++; $display("FAIL gnt_pop got ccnt=%0d addr=%h rdy=%b want 3 808 1", dut.commit_cnt_q, mem_addr_o, commit_ready_o); end
      mem_gnt_i = 1; commit_i = 1; tick(); mem_gnt_i = 0; commit_i = 0; #1;
      nvec++; if (dut.commit_cnt_q !== 3'd3 || dut.spec_cnt_q !== 3'd0 || mem_addr_o !== 56'h810) begin
         nerr++; $display("FAIL gnt_commit got ccnt=%0d cnt=%0d addr=%h want 3 0 810", dut.commit_cnt_q, dut.spec_cnt_q, mem_addr_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      push(56'hA00, 64'h55, 8'hFF);
      push(56'hA08, 64'h66, 8'hFF);
      commit_i = 1; tick(); commit_i = 0;
      lookup(56'hA08, 8'hFF);
      nvec++; if (fwd_hit_o !== 1'b1 || fwd_data_o !== 64'h66 || mem_req_o !== 1'b1) begin
         nerr++; $display("FAIL pre_reset got hit=%b data=%h req=%b want 1 66 1", fwd_hit_o, fwd_data_o, mem_req_o); end
      #2 rst_i = 1; #1;
      nvec++; if ({ready_o, commit_ready_o, no_st_pending_o, mem_req_o, fwd_hit_o, ld_stall_o} !== 6'b111000) begin
         nerr++; $display("FAIL mid_reset got %b want 111000", {ready_o, commit_ready_o, no_st_pending_o, mem_req_o, fwd_hit_o, ld_stall_o}); end
      tick(); rst_i = 0; tick();
      lookup(56'hA00, 8'hFF);
      nvec++; if (fwd_hit_o !== 1'b0 || ld_stall_o !== 1'b0 || no_st_pending_o !== 1'b1) begin
         nerr++; $display("FAIL post_reset got hit=%b stall=%b nsp=%b want 0 0 1", fwd_hit_o, ld_stall_o, no_st_pending_o); end
      ld_valid_i = 0;
   endtask

   initial begin
      test_reset();
      test_commit_drain();
      test_full_wrap();
      test_forward();
      test_flush();
      test_commit_full();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/store_queue_fwd.md
STORE_QUEUE_FWD -- requirements
Module: store_queue_fwd

Interface
REQ-001 SHALL have parameter SPEC_DEPTH, default 4, speculative-queue entries (power of two, >=2).
REQ-002 SHALL have parameter COMMIT_DEPTH, default 4, commit-queue entries (power of two, >=2).
REQ-003 SHALL have parameter DATA_W, default 64, store data width in bits (multiple of 8); BE_W = DATA_W/8.
REQ-004 SHALL have parameter ADDR_W, default 56, physical address width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 SHALL have the following ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  discard speculative stores
- valid_i  in  1  push a store
- ready_o  out  1  push accepted
- paddr_i  in  ADDR_W  store address
- data_i  in  DATA_W  store data
- be_i  in  BE_W  store byte enables
- size_i  in  2  store size
- commit_i  in  1  commit the oldest speculative store
- commit_ready_o  out  1  commit accepted
- no_st_pending_o  out  1  commit queue empty
- ld_valid_i  in  1  load lookup
- ld_paddr_i  in  ADDR_W  load address
- ld_be_i  in  BE_W  load byte enables
- fwd_hit_o  out  1  forwarding data valid
- fwd_data_o  out  DATA_W  forwarded data
- ld_stall_o  out  1  load must wait
- mem_req_o  out  1  memory write request
- mem_gnt_i  in  1  memory grant
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory data
- mem_be_o  out  BE_W  memory byte enables
- mem_size_o  out  2  memory size

Function
REQ-007 SHALL hold two circular FIFOs, speculative (SPEC_DEPTH) and commit (COMMIT_DEPTH); each has read and write pointers of log2(depth) bits that wrap modulo depth, and an occupancy counter of log2(depth)+1 bits.
REQ-008 SHALL drive ready_o = (spec_cnt < SPEC_DEPTH) | (commit_i & commit_ready_o & spec_cnt != 0), combinationally.
REQ-009 SHALL write {paddr,data,be,size,valid=1} at the speculative write pointer on valid_i & ready_o & !flush_i; valid_i while !ready_o SHALL be ignored.
REQ-010 SHALL drive commit_ready_o = commit_cnt < COMMIT_DEPTH.
REQ-011 SHALL, on commit_i & commit_ready_o & spec_cnt != 0, copy the speculative head into the commit queue at its write pointer in the same cycle and advance both pointers; otherwise commit_i SHALL have no effect.
REQ-012 SHALL, on flush_i, clear every speculative valid bit, set speculative write pointer := next read pointer, and set spec_cnt := 0. A commit in the same cycle SHALL complete before the clear; a push in the same cycle SHALL be dropped. The commit queue SHALL be unaffected.
REQ-013 SHALL drive mem_req_o = commit head valid; mem_addr/data/be/size_o SHALL come from the commit head; mem_gnt_i & mem_req_o SHALL pop the head in that cycle; mem_gnt_i without a request SHALL be ignored.
REQ-014 SHALL update both counters correctly when push, commit and grant occur together (net count change = pushes minus pops per queue).
REQ-015 SHALL drive no_st_pending_o = (commit_cnt == 0).
REQ-016 SHALL compare, when ld_valid_i=1, ld_paddr_i[ADDR_W-1:log2(BE_W)] against every valid entry of both queues; the selected entry SHALL be the youngest match, searching the speculative queue youngest-first, then the commit queue youngest-first.
REQ-017 SHALL assert fwd_hit_o=1 with fwd_data_o = selected data if (ld_be_i & ~entry.be) == 0; otherwise, with a match, ld_stall_o=1 and fwd_hit_o=0.
REQ-018 SHALL assert ld_stall_o=1 if a push accepted in the same cycle matches the load word address, regardless of queue hits.
REQ-019 SHALL drive fwd_hit_o=0, ld_stall_o=0 and fwd_data_o=0 when ld_valid_i=0 or when nothing matches; lookup SHALL be combinational (zero latency).

Reset
REQ-020 SHALL, on rst_i, asynchronously clear all pointers, counters, and valid bits; entry payloads SHALL reset to 0.
REQ-021 SHALL, during and after reset, drive ready_o=1, commit_ready_o=1, no_st_pending_o=1, mem_req_o=0, fwd_hit_o=0, ld_stall_o=0.
REQ-022 SHALL discard all entries on reset asserted mid-transfer; no grant is awaited.

Verification
REQ-023 Push A(0x100,data 0x11..,be 0xFF), commit, gnt held 0 -> mem_req_o=1, mem_addr_o=0x100, no_st_pending_o=0; gnt=1 -> next cycle mem_req_o=0, no_st_pending_o=1.
REQ-024 Push SPEC_DEPTH stores with no commit -> ready_o=0; commit_i=1 in the same cycle as a push -> push accepted, spec_cnt stays SPEC_DEPTH; pointers wrap to 0.
REQ-025 Push stores to 0x200 then 0x200 (be 0xFF, data 1 then 2), ld 0x204 be 0xF0 -> fwd_hit_o=1, fwd_data_o=2; store be 0x0F only, load be 0xFF -> ld_stall_o=1.
REQ-026 3 speculative stores, commit_i & flush_i together -> commit_cnt=1, spec_cnt=0; next lookup of the flushed addresses -> no hit.
REQ-027 Fill the commit queue with gnt=0 -> commit_ready_o=0 and commit_i ignored; gnt and commit in the same cycle with count COMMIT_DEPTH-1 -> count unchanged.
REQ-028 Assert rst_i with both queues occupied -> all outputs at their reset values immediately; after release, lookup misses.
